// File: rtl/pipe_stage_reg_if.sv
// Bundle of the stage-boundary signals between two pipeline stages.
// PIPE_STAGE_STAT_EN adds the stall/bubble counter outputs.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RF_W   = 5
);
    logic              stall;
    logic              flush;
    logic              valid_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [ADDR_W-1:0] pc4_i;
    logic [31:0]       ir_i;
    logic [RF_W-1:0]   rf_addr_i;

    logic              valid_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] pc4_o;
    logic [31:0]       ir_o;
    logic [RF_W-1:0]   rf_addr_o;
    logic              rf_we_o;

`ifdef PIPE_STAGE_STAT_EN
    logic [31:0]       stall_cnt_o;
    logic [31:0]       bubble_cnt_o;

    modport master (
        output stall, flush, valid_i, alu_result_i, mem_data_i, pc4_i, ir_i, rf_addr_i,
        input  valid_o, alu_result_o, mem_data_o, pc4_o, ir_o, rf_addr_o, rf_we_o,
        input  stall_cnt_o, bubble_cnt_o
    );
    modport slave (
        input  stall, flush, valid_i, alu_result_i, mem_data_i, pc4_i, ir_i, rf_addr_i,
        output valid_o, alu_result_o, mem_data_o, pc4_o, ir_o, rf_addr_o, rf_we_o,
        output stall_cnt_o, bubble_cnt_o
    );
`else
    modport master (
        output stall, flush, valid_i, alu_result_i, mem_data_i, pc4_i, ir_i, rf_addr_i,
        input  valid_o, alu_result_o, mem_data_o, pc4_o, ir_o, rf_addr_o, rf_we_o
    );
    modport slave (
        input  stall, flush, valid_i, alu_result_i, mem_data_i, pc4_i, ir_i, rf_addr_i,
        output valid_o, alu_result_o, mem_data_o, pc4_o, ir_o, rf_addr_o, rf_we_o
    );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall (hold), flush (bubble) and valid tracking.
// Optional PIPE_STAGE_STAT_EN adds saturating stall and bubble counters.
module pipe_stage_reg #(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 32,
    parameter int                RF_W          = 5,
    parameter logic [ADDR_W-1:0] PC_RESET      = 32'h0000_3004,
    parameter bit                FLUSH_KEEP_PC = 1'b1
) (
    input logic             clk,
    input logic             reset,
    pipe_stage_reg_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_data;
        logic [ADDR_W-1:0] pc4;
        logic [31:0]       ir;
        logic [RF_W-1:0]   rf_addr;
    } stage_t;

    localparam stage_t STAGE_RESET = '{
        valid:      1'b0,
        alu_result: '0,
        mem_data:   '0,
        pc4:        PC_RESET,
        ir:         '0,
        rf_addr:    '0
    };

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        // NOTE: hold is the default, so every path assigns stage_d and no latch is inferred.
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d     = STAGE_RESET;
            stage_d.pc4 = FLUSH_KEEP_PC ? bus.pc4_i : PC_RESET;
        end else if (!bus.stall) begin
            stage_d.valid      = bus.valid_i;
            stage_d.alu_result = bus.alu_result_i;
            stage_d.mem_data   = bus.mem_data_i;
            stage_d.pc4        = bus.pc4_i;
            stage_d.ir         = bus.ir_i;
            stage_d.rf_addr    = bus.rf_addr_i;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stage_q <= STAGE_RESET;
        else       stage_q <= stage_d;
    end

    assign bus.valid_o      = stage_q.valid;
    assign bus.alu_result_o = stage_q.alu_result;
    assign bus.mem_data_o   = stage_q.mem_data;
    assign bus.pc4_o        = stage_q.pc4;
    assign bus.ir_o         = stage_q.ir;
    assign bus.rf_addr_o    = stage_q.rf_addr;
    // $0 is hardwired to zero, so writes to it are never strobed.
    assign bus.rf_we_o      = stage_q.valid && (stage_q.rf_addr != '0);

`ifdef PIPE_STAGE_STAT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;
    logic        hold_evt;
    logic        bubble_evt;

    assign hold_evt   = bus.stall && !bus.flush;
    assign bubble_evt = bus.flush || (!bus.stall && !bus.valid_i);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (hold_evt && (stall_cnt_q != '1))    stall_cnt_q  <= stall_cnt_q + 32'd1;
            if (bubble_evt && (bubble_cnt_q != '1)) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cnt_o  = stall_cnt_q;
    assign bus.bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// compared against a behavioural model of the stage-register rules.
module tb_pipe_stage_reg;

    localparam logic [31:0] PC_RST = 32'h0000_3004;
    localparam bit          KEEP_PC = 1'b1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_stage_reg_if bus_if ();
    pipe_stage_reg dut (.clk(clk), .reset(reset), .bus(bus_if));

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference state
    logic        m_valid;
    logic [31:0] m_alu, m_mem, m_pc4, m_ir;
    logic [4:0]  m_rf;
    logic [31:0] m_stall_cnt, m_bubble_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_alu = '0; m_mem = '0; m_pc4 = PC_RST; m_ir = '0; m_rf = '0;
        m_stall_cnt = '0; m_bubble_cnt = '0;
    endtask

    // One rising edge: advance the model with the inputs present at the edge, then settle.
    task automatic clock_edge();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            if (bus_if.stall && !bus_if.flush) m_stall_cnt = sat_inc(m_stall_cnt);
            if (bus_if.flush || (!bus_if.stall && !bus_if.valid_i)) m_bubble_cnt = sat_inc(m_bubble_cnt);
            if (bus_if.flush) begin
                m_valid = 1'b0; m_alu = '0; m_mem = '0; m_ir = '0; m_rf = '0;
                m_pc4 = KEEP_PC ? bus_if.pc4_i : PC_RST;
            end else if (!bus_if.stall) begin
                m_valid = bus_if.valid_i; m_alu = bus_if.alu_result_i; m_mem = bus_if.mem_data_i;
                m_pc4 = bus_if.pc4_i; m_ir = bus_if.ir_i; m_rf = bus_if.rf_addr_i;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [31:0] ir, input logic [4:0] rf);
        bus_if.valid_i = v; bus_if.alu_result_i = alu; bus_if.mem_data_i = mem;
        bus_if.pc4_i = pc; bus_if.ir_i = ir; bus_if.rf_addr_i = rf;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.stall = 1'b0; bus_if.flush = 1'b0;
        drive(1'b1, 32'hAAAA_5555, 32'h5555_AAAA, 32'h0000_4000, 32'hFFFF_FFFF, 5'd31);
        model_reset();
        #1;
        n_cmp++; if (bus_if.pc4_o !== PC_RST) begin n_bad++; $display("FAIL reset_pc4 got=%h exp=%h", bus_if.pc4_o, PC_RST); end
        n_cmp++; if (bus_if.ir_o !== 32'd0) begin n_bad++; $display("FAIL reset_ir got=%h exp=0", bus_if.ir_o); end
        n_cmp++; if (bus_if.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid_o); end
        n_cmp++; if (bus_if.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we got=%b exp=0", bus_if.rf_we_o); end
        clock_edge();
        n_cmp++; if (bus_if.rf_addr_o !== 5'd0) begin n_bad++; $display("FAIL reset_held_rf got=%h exp=0", bus_if.rf_addr_o); end
        #2 reset = 1'b0;
    endtask

    task automatic test_pass_through();
        drive(1'b1, 32'h0000_1234, 32'hCAFE_0001, 32'h0000_3008, 32'h0109_5021, 5'd10);
        clock_edge();
        n_cmp++; if (bus_if.ir_o !== 32'h0109_5021) begin n_bad++; $display("FAIL pass_ir got=%h exp=01095021", bus_if.ir_o); end
        n_cmp++; if (bus_if.rf_addr_o !== 5'd10) begin n_bad++; $display("FAIL pass_rf got=%0d exp=10", bus_if.rf_addr_o); end
        n_cmp++; if (bus_if.alu_result_o !== 32'h1234) begin n_bad++; $display("FAIL pass_alu got=%h exp=1234", bus_if.alu_result_o); end
        n_cmp++; if (bus_if.mem_data_o !== 32'hCAFE_0001) begin n_bad++; $display("FAIL pass_mem got=%h exp=cafe0001", bus_if.mem_data_o); end
        n_cmp++; if (bus_if.rf_we_o !== 1'b1) begin n_bad++; $display("FAIL pass_we got=%b exp=1", bus_if.rf_we_o); end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h11, 32'h22, 32'h0000_300C, 32'h2002_000A, 5'd10);
        clock_edge();
        bus_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h99 + i, 32'h77, 32'h0000_3100, 32'h2002_0007, 5'd7);
            clock_edge();
            n_cmp++; if (bus_if.rf_addr_o !== 5'd10 || bus_if.valid_o !== 1'b1)
                begin n_bad++; $display("FAIL stall_hold[%0d] got rf=%0d v=%b exp rf=10 v=1", i, bus_if.rf_addr_o, bus_if.valid_o); end
        end
        bus_if.stall = 1'b0;
        drive(1'b1, 32'h99, 32'h77, 32'h0000_3100, 32'h2002_0007, 5'd7);
        clock_edge();
        n_cmp++; if (bus_if.rf_addr_o !== 5'd7) begin n_bad++; $display("FAIL stall_release got=%0d exp=7", bus_if.rf_addr_o); end
    endtask

    task automatic test_flush_priority();
        bus_if.stall = 1'b1; bus_if.flush = 1'b1;
        drive(1'b1, 32'h55, 32'h66, 32'h0000_3010, 32'h0109_5021, 5'd12);
        clock_edge();
        n_cmp++; if (bus_if.valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", bus_if.valid_o); end
        n_cmp++; if (bus_if.ir_o !== 32'd0) begin n_bad++; $display("FAIL flush_ir got=%h exp=0", bus_if.ir_o); end
        n_cmp++; if (bus_if.rf_we_o !== 1'b0) begin n_bad++; $display("FAIL flush_we got=%b exp=0", bus_if.rf_we_o); end
        n_cmp++; if (bus_if.pc4_o !== 32'h0000_3010) begin n_bad++; $display("FAIL flush_pc4 got=%h exp=3010", bus_if.pc4_o); end
        n_cmp++; if (bus_if.alu_result_o !== 32'd0 || bus_if.rf_addr_o !== 5'd0)
            begin n_bad++; $display("FAIL flush_fields got alu=%h rf=%0d exp 0/0", bus_if.alu_result_o, bus_if.rf_addr_o); end
        bus_if.stall = 1'b0; bus_if.flush = 1'b0;
    endtask

    task automatic test_zero_dest();
        drive(1'b1, 32'h1, 32'h2, 32'h0000_3014, 32'h0000_0020, 5'd0);
        clock_edge();
        n_cmp++; if (bus_if.valid_o !== 1'b1 || bus_if.rf_we_o !== 1'b0)
            begin n_bad++; $display("FAIL zero_dest got v=%b we=%b exp v=1 we=0", bus_if.valid_o, bus_if.rf_we_o); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 32'h42, 32'h43, 32'h0000_3020, 32'h1234_5678, 5'd3);
        clock_edge();
        bus_if.stall = 1'b1;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (bus_if.pc4_o !== PC_RST || bus_if.valid_o !== 1'b0 || bus_if.ir_o !== 32'd0 || bus_if.rf_we_o !== 1'b0)
            begin n_bad++; $display("FAIL async_reset got pc=%h v=%b ir=%h we=%b", bus_if.pc4_o, bus_if.valid_o, bus_if.ir_o, bus_if.rf_we_o); end
        bus_if.stall = 1'b0;
        clock_edge();
        n_cmp++; if (bus_if.valid_o !== 1'b0 || bus_if.rf_addr_o !== 5'd0)
            begin n_bad++; $display("FAIL reset_over_edge got v=%b rf=%0d exp 0/0", bus_if.valid_o, bus_if.rf_addr_o); end
        #2 reset = 1'b0;
        clock_edge();
        n_cmp++; if (bus_if.rf_addr_o !== 5'd3 || bus_if.valid_o !== 1'b1)
            begin n_bad++; $display("FAIL after_reset got rf=%0d v=%b exp 3/1", bus_if.rf_addr_o, bus_if.valid_o); end
    endtask

    task automatic test_random();
        logic [134:0] got, exp;
        for (int i = 0; i < 300; i++) begin
            bus_if.stall = ($urandom_range(0, 3) == 0);
            bus_if.flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                  $urandom, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom));
            clock_edge();
            got = {bus_if.valid_o, bus_if.alu_result_o, bus_if.mem_data_o, bus_if.pc4_o,
                   bus_if.ir_o, bus_if.rf_addr_o, bus_if.rf_we_o};
            exp = {m_valid, m_alu, m_mem, m_pc4, m_ir, m_rf, m_valid && (m_rf != 5'd0)};
            n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL random[%0d] got=%h exp=%h", i, got, exp); end
`ifdef PIPE_STAGE_STAT_EN
            n_cmp++; if (bus_if.stall_cnt_o !== m_stall_cnt || bus_if.bubble_cnt_o !== m_bubble_cnt)
                begin n_bad++; $display("FAIL random_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, bus_if.stall_cnt_o, bus_if.bubble_cnt_o, m_stall_cnt, m_bubble_cnt); end
`endif
        end
        bus_if.stall = 1'b0; bus_if.flush = 1'b0;
    endtask

`ifdef PIPE_STAGE_STAT_EN
    task automatic test_stat_counters();
        #2 reset = 1'b1;
        bus_if.stall = 1'b1; bus_if.flush = 1'b0;
        drive(1'b1, 32'h1, 32'h2, 32'h0000_3030, 32'h1, 5'd4);
        #1 reset = 1'b0;
        model_reset();
        clock_edge();
        clock_edge();
        bus_if.flush = 1'b1;
        clock_edge();
        n_cmp++; if (bus_if.stall_cnt_o !== 32'd2 || bus_if.bubble_cnt_o !== 32'd1)
            begin n_bad++; $display("FAIL stat_counts got=%0d/%0d exp=2/1", bus_if.stall_cnt_o, bus_if.bubble_cnt_o); end
        bus_if.flush = 1'b0;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        m_stall_cnt = 32'hFFFF_FFFF;
        clock_edge();
        n_cmp++; if (bus_if.stall_cnt_o !== 32'hFFFF_FFFF)
            begin n_bad++; $display("FAIL stat_saturate got=%h exp=ffffffff", bus_if.stall_cnt_o); end
        bus_if.stall = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_pass_through();
        test_stall();
        test_flush_priority();
        test_zero_dest();
        test_reset_mid_stall();
        test_random();
`ifdef PIPE_STAGE_STAT_EN
        test_stat_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-width MEM/WB latch.
- One block instantiated for every inter-stage boundary (F/D, D/E, E/M, M/W) of the 5-stage MIPS core.
- Adds stall (hold), flush (bubble insertion), a per-stage valid bit and a derived register-write strobe.
- Widths and the PC reset vector are parameters, so one module serves all boundaries.

Parameters:
- DATA_W, 32, width of the alu_result and mem_data fields.
- ADDR_W, 32, width of the pc4 field.
- RF_W, 5, width of the register-file destination address.
- PC_RESET, 32'h0000_3004, value loaded into pc4_o on reset (text base 0x3000 + 4).
- FLUSH_KEEP_PC, 1, when 1 a flush still captures pc4_i (EPC tracking); when 0 a flush loads PC_RESET.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hold all outputs this cycle
- flush  in  1  replace incoming instruction with a bubble
- valid_i  in  1  upstream slot holds a real instruction
- alu_result_i  in  DATA_W  ALU result from previous stage
- mem_data_i  in  DATA_W  memory read data from previous stage
- pc4_i  in  ADDR_W  PC+4 of instruction
- ir_i  in  32  instruction word
- rf_addr_i  in  RF_W  destination register address
- valid_o  out  1  registered valid
- alu_result_o  out  DATA_W  registered alu_result_i
- mem_data_o  out  DATA_W  registered mem_data_i
- pc4_o  out  ADDR_W  registered pc4_i
- ir_o  out  32  registered ir_i
- rf_addr_o  out  RF_W  registered rf_addr_i
- rf_we_o  out  1  combinational: valid_o and (rf_addr_o != 0)

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - valid_o, alu_result_o, mem_data_o, ir_o, rf_addr_o = 0.
  - pc4_o = PC_RESET.
  - rf_we_o = 0.
- Each rising edge with reset low, evaluate in priority order:
  1. flush=1 (overrides stall):
     - valid_o=0, ir_o=0 (nop), rf_addr_o=0, alu_result_o=0, mem_data_o=0.
     - pc4_o = pc4_i if FLUSH_KEEP_PC=1, else PC_RESET.
  2. stall=1, flush=0: every output holds its previous value, including valid_o.
  3. otherwise: all fields capture their inputs; valid_o = valid_i.
- Latency: exactly one cycle from input to output; no combinational path from inputs to outputs except rf_we_o (derived from registered values only).
- A register write to $0 never asserts rf_we_o, even with valid_o=1.
- Stall held for N cycles leaves the outputs frozen for N cycles; the first edge after stall deasserts captures the current inputs.
- Reset asserted mid-stall or mid-flush wins immediately. Outputs stay at reset values until the first edge after reset deasserts.
- All register updates use non-blocking assignment; no initial blocks (reset is the only initialisation).

Optional Feature:
- Macro: PIPE_STAGE_STAT_EN.
- Defined: adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0], both cleared by reset.
  - stall_cnt_o increments on each edge with stall=1, flush=0.
  - bubble_cnt_o increments on each edge where valid_o is loaded with 0 (flush, or valid_i=0 with no stall).
  - Both saturate at 32'hFFFF_FFFF (no wrap).
- Undefined: the ports and counters do not exist; behaviour of all other ports is identical.

Test Plan:
- Reset: assert reset between clock edges → outputs change immediately: pc4_o=32'h3004, ir_o=0, valid_o=0, rf_we_o=0.
- Pass-through: valid_i=1, ir_i=32'h0109_5021, rf_addr_i=10, alu_result_i=32'h1234 → one edge later ir_o=32'h0109_5021, rf_addr_o=10, alu_result_o=32'h1234, rf_we_o=1.
- Stall: load rf_addr=10, then stall=1 for 3 cycles while inputs change to rf_addr_i=7 → outputs keep rf_addr_o=10 for 3 cycles; rf_addr_o=7 on the first edge after stall drops.
- Flush priority: stall=1, flush=1, pc4_i=32'h3010 → valid_o=0, ir_o=0, rf_we_o=0, pc4_o=32'h3010 (FLUSH_KEEP_PC=1).
- $0 destination: valid_i=1, rf_addr_i=0 → valid_o=1, rf_we_o=0.
- With PIPE_STAGE_STAT_EN: 2 stall cycles + 1 flush → stall_cnt_o=2, bubble_cnt_o=1. Force the counter to 32'hFFFF_FFFF, then stall once more → it stays at 32'hFFFF_FFFF.
